// File: rtl/present80_pkg.sv
// Shared widths, S-box table and key-schedule state encoding for PRESENT-80.
package present80_pkg;

  localparam int unsigned KEY_W      = 80;
  localparam int unsigned BLK_W      = 64;
  localparam int unsigned RK_LO      = 16;
  localparam int unsigned RND_W      = 6;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned ROUNDS_DEF = 31;

  // Nibble i of the table holds S(i): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  localparam logic [63:0] SBOX_LUT = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_e;

  // PRESENT 4-bit S-box lookup.
  function automatic logic [NIB_W-1:0] present_sbox(input logic [NIB_W-1:0] x);
    return SBOX_LUT[{x, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/present_sbox4.sv
// 4-bit PRESENT S-box; combinational, reused by the round sBox layer.
module present_sbox4
  import present80_pkg::*;
(
  input  logic [NIB_W-1:0] din_i,
  output logic [NIB_W-1:0] dout_o
);

  assign dout_o = present_sbox(din_i);

endmodule

// File: rtl/present80_keysched.sv
// PRESENT-80 round-key generator: holds the key register, advances it on next,
// and presents K1..K(ROUNDS+1) with round index and valid/last flags.
module present80_keysched
  import present80_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             next,
  output logic [BLK_W-1:0] rk,
  output logic [RND_W-1:0] rnd,
  output logic             rk_valid,
  output logic             last
);

  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(1);
  localparam logic [RND_W-1:0] RND_PRE   = RND_W'(ROUNDS);

  ks_state_e        state_q;
  logic [KEY_W-1:0] key_q;
  logic [RND_W-1:0] rnd_q;
  logic             valid_q;
  logic             last_q;

  logic [KEY_W-1:0] key_rot;
  logic [KEY_W-1:0] key_d;
  logic [NIB_W-1:0] sbox_out;

  // Rotate left by 61: the old low 19 bits become the new top.
  assign key_rot = {key_q[18:0], key_q[KEY_W-1:19]};

  present_sbox4 u_sbox (
    .din_i  (key_rot[KEY_W-1 -: NIB_W]),
    .dout_o (sbox_out)
  );

  // Next key: S-box on the top nibble, round counter folded into bits 19..15.
  always_comb begin
    key_d                 = key_rot;
    key_d[KEY_W-1 -: NIB_W] = sbox_out;
    key_d[19:15]          = key_rot[19:15] ^ rnd_q[CNT_W-1:0];
  end

  // Sequencer: reset beats load, load beats next, next only acts in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      state_q <= ST_RUN;
      key_q   <= key_in;
      rnd_q   <= RND_FIRST;
      valid_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (next) begin
            key_q <= key_d;
            rnd_q <= rnd_q + RND_FIRST;
            if (rnd_q == RND_PRE) begin
              state_q <= ST_DONE;
              last_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rk       = key_q[KEY_W-1:RK_LO];
  assign rnd      = rnd_q;
  assign rk_valid = valid_q;
  assign last     = last_q;

endmodule

// File: doc/present80_keysched.md
Name: present80_keysched

Overview:
- Round-key generator for the PRESENT-80 round datapath.
- Holds the 80-bit key register and applies the PRESENT-80 key update once per advance request.
- Presents the current 64-bit round key to the addRoundKey XOR, which sits upstream of the sBox layer and bit permutation.
- Sequenced by the round controller through a load/next handshake.

Parameters:
ROUNDS, 31, number of cipher rounds; legal range 1..31; the block produces round keys K1..K(ROUNDS+1).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  capture key_in and restart at K1
key_in  input  80  user key; bit 79 is the MSB (k79)
next  input  1  advance to the next round key
rk  output  64  current round key = key register bits 79..16
rnd  output  6  index i of the round key on rk (1..ROUNDS+1); 0 when idle
rk_valid  output  1  rk/rnd are valid
last  output  1  rk is the final key K(ROUNDS+1)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - key register = 0, rnd = 0, rk_valid = 0, last = 0.
  - rk therefore reads 0.
  - rst overrides load and next in the same cycle.
- States:
  - IDLE: rk_valid = 0.
  - RUN: rk_valid = 1, rnd < ROUNDS+1.
  - DONE: rk_valid = 1, rnd = ROUNDS+1, last = 1.
- load, from any state:
  - Next edge: key register <= key_in, rnd <= 1, state RUN.
  - Latency 1 cycle: K1 = key_in[79:16] on rk the cycle after load.
- next in RUN, without load:
  - Update with counter c = rnd[4:0]:
    1. Rotate the key register left by 61: new[79:0] = old[18:0] concatenated with old[79:19].
    2. new[79:76] <= S(new[79:76]), using the PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
    3. new[19:15] ^= c.
  - rnd <= rnd+1.
  - If rnd+1 = ROUNDS+1, go to DONE.
  - Latency 1 cycle; one update per cycle when next is held high.
- next in IDLE or DONE: ignored; register, rnd and flags unchanged.
- load and next together: load wins and next is dropped.
- Counter width:
  - rnd is 6 bits to hold 32.
  - Only bits 4..0 are XORed; c ranges 1..31 and never reaches 32 during an update.
- Outputs:
  - rk is taken combinationally from the register only; there is no combinational path from inputs.
  - last = rk_valid AND (rnd == ROUNDS+1).
- Reset mid-sequence: returns to IDLE at the next edge; the sequence resumes only on a fresh load.
- Timing: the S-box is on the register feedback path only; the update is one 4-bit S-box plus a 5-bit XOR deep.

Decomposition:
- Package present80_pkg:
  - KEY_W = 80, BLK_W = 64, RK_LO = 16.
  - S-box lookup constant and function.
  - Default ROUNDS = 31.
  - State enum IDLE/RUN/DONE.
- Sub-module present_sbox4: 4-bit combinational S-box. It is shared with the sBox-layer stage (16 instances there, 1 here).

Test Plan:
1. Key 0x0000_0000_0000_0000_0000, load, then one next:
   - K1: rk = 0000000000000000, rnd = 1.
   - K2: rk = C000000000000000, internal register = C000_0000_0000_0000_8000, rnd = 2.
2. Key all ones, load, then one next:
   - K1: rk = FFFFFFFFFFFFFFFF.
   - K2: rk = 2FFFFFFFFFFFFFFF, register low 16 bits = 7FFF.
3. Load a random key, hold next high for 40 cycles:
   - rnd steps 1..32, each rk matches the golden model.
   - last rises with rnd = 32; the remaining 9 next cycles leave rk and rnd unchanged.
   - Full encryption of plaintext 0 with key 0 through the round datapath gives ciphertext 5579C1387B228445.
4. load and next asserted together while at rnd = 10 -> next cycle rnd = 1, rk = new key_in[79:16]; no update is applied.
5. rst asserted at rnd = 17 with next high -> next cycle rk_valid = 0, rnd = 0, rk = 0; a subsequent next with no load leaves the block in IDLE.
6. ROUNDS = 4 build: load then 6 next pulses -> rnd 1..5, last at rnd = 5, keys match the first 5 golden round keys.
